fp_narrow: RTL and testbench
============================

Name: fp_narrow

Overview:
- Pipelined IEEE754 narrowing converter: wide format (INX/INM) to narrow format (ONX/ONM), for example double to single.
- Performs round-to-nearest-even, saturation to infinity, subnormal flush-to-zero and NaN quieting.
- Valid/ready streaming on both sides. Sits on the write-back path of FP datapaths that compute in wide format and store or emit narrow format.

Parameters:
- INX, 11, input exponent width
- INM, 52, input mantissa width; must be > ONM
- ONX, 8, output exponent width; must be <= INX
- ONM, 23, output mantissa width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  converter can accept an input this cycle
- in_data  in  INX+INM+1  input {sign, exp, mant}
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts the output this cycle
- out_data  out  ONX+ONM+1  output {sign, exp, mant}
- out_flags  out  4  {overflow, underflow, inexact, nan}

Behaviour:
- Reset (async assert, sync release): all stage valids 0, out_valid=0, out_data=0, out_flags=0. in_ready=1 in the first cycle after release. In-flight words are discarded.
- Two registered stages:
  - S1: unpack, classify, rebias.
  - S2: round, pack, flags.
- Latency: 2 cycles from input handshake to out_valid with no stall. Throughput 1 word/cycle.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - S2 loads when !s2_valid || out_ready.
  - S1 loads when !s1_valid || S2 loads.
  - in_ready = !s1_valid || S2 loads (combinational through out_ready, no skid buffer).
  - out_data and out_flags hold stable while out_valid && !out_ready.
- Rebias:
  - IXOFF = 2^(INX-1)-1, OXOFF = 2^(ONX-1)-1.
  - ox = exp - IXOFF + OXOFF, computed signed with INX+2 bits.
- Classification priority, highest first:
  1. exp all ones, mant != 0: quiet NaN. Output exp all ones, mant = {1, top ONM-1 bits of the input mant below its MSB}, sign kept. Flags: nan=1, others 0.
  2. exp all ones, mant == 0: signed infinity. Flags 0.
  3. exp == 0: signed zero. If mant != 0, set underflow and inexact.
  4. ox <= 0: signed zero (no subnormal output). Flags: underflow=1, inexact=1.
  5. ox >= 2^ONX-1: signed infinity. Flags: overflow=1, inexact=1.
  6. Otherwise normal rounding.
- Rounding (class 6):
  - kept = top ONM bits of mant.
  - guard = the next bit below kept.
  - sticky = OR of the remaining INM-ONM-1 bits.
  - Round up iff guard && (sticky || kept[0]).
  - Carry out of the mantissa: mant=0, ox+1. If ox+1 == 2^ONX-1, the result is signed infinity and overflow=1.
  - inexact = guard | sticky.
- Simultaneous events: an input handshake and an output handshake in the same cycle both complete, and the pipeline shifts. in_valid with in_ready=0 is held by the producer; the block does not capture it.

Decomposition:
- Shared package fp_pkg:
  - EXP_OFFSET and IEEE754 field typedef macros
  - flag bit index constants FLG_OVF, FLG_UNF, FLG_INX, FLG_NAN
  - classification enum {CL_NAN, CL_INF, CL_ZERO, CL_NORM}
- One sub-module: fp_round_rne. Purely combinational; takes kept/guard/sticky/ox and returns mantissa, exponent, carry, inexact and overflow. Instantiated in S2.

Test Plan (double to single, defaults):
- 0x3FF0000000000000 -> 0x3F800000, flags 0000, out_valid exactly 2 cycles after the input handshake.
- Round to nearest even:
  - 0x3FF0000010000000 -> 0x3F800000, inexact (tie, even kept).
  - 0x3FF0000030000000 -> 0x3F800002, inexact (tie, odd rounded up).
- Overflow:
  - 0x47F0000000000000 -> 0x7F800000, overflow+inexact.
  - 0x47EFFFFFF0000000 -> 0x7F800000 via rounding carry, overflow+inexact.
- Special values:
  - 0x7FF8000000000000 -> 0x7FC00000, nan.
  - 0xFFF0000000000000 -> 0xFF800000, flags 0.
  - 0x3690000000000000 -> 0x00000000, underflow+inexact.
- Backpressure: stream 8 distinct words with out_ready toggling 1,0,0,1,...
  - All 8 outputs appear in order with no loss or duplication.
  - out_data stays stable during stalls.
  - in_ready drops once both stages are full.
- Reset mid-stream: assert rst_n=0 with both stages valid.
  - out_valid falls to 0 immediately (async).
  - After release, no stale output appears.
  - The next input yields the correct result 2 cycles later.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the IEEE754 narrowing datapath.
//   FP_FIELDS_T   - macro that declares a packed {sign, exp, mant} struct type
//   exp_offset()  - exponent bias for a given exponent width
//   FLG_*         - bit positions inside the 4-bit flag word {ovf, unf, inx, nan}
//   fp_class_e    - operand class carried from unpack to pack
`define FP_FIELDS_T(name, xw, mw) typedef struct packed { logic sign; logic [(xw)-1:0] exp; logic [(mw)-1:0] mant; } name

package fp_pkg;

  localparam int FLG_NAN = 0;
  localparam int FLG_INX = 1;
  localparam int FLG_UNF = 2;
  localparam int FLG_OVF = 3;

  typedef enum logic [1:0] {
    CL_NAN  = 2'd0,
    CL_INF  = 2'd1,
    CL_ZERO = 2'd2,
    CL_NORM = 2'd3
  } fp_class_e;

  // Bias of an IEEE754 exponent field of width w: 2^(w-1)-1.
  function automatic int exp_offset(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// fp_round_rne: combinational round-to-nearest-even for a normal result.
//   i_kept     - ONM retained mantissa bits
//   i_guard    - first discarded bit
//   i_sticky   - OR of all remaining discarded bits
//   i_ox       - rebiased output exponent (signed, INX+2 bits), known in range
//   o_mant     - rounded mantissa (zero when the increment carries out)
//   o_exp      - output exponent after a possible carry
//   o_carry    - mantissa increment carried out
//   o_inexact  - any discarded bit was set
//   o_overflow - carry pushed the exponent to the all-ones (infinity) code
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int INX = 11,
  parameter int ONX = 8,
  parameter int ONM = 23
) (
  input  logic [ONM-1:0]        i_kept,
  input  logic                  i_guard,
  input  logic                  i_sticky,
  input  logic signed [INX+1:0] i_ox,
  output logic [ONM-1:0]        o_mant,
  output logic [ONX-1:0]        o_exp,
  output logic                  o_carry,
  output logic                  o_inexact,
  output logic                  o_overflow
);

  localparam logic signed [INX+1:0] OX_MAX = (INX+2)'((1 << ONX) - 1);

  logic           w_round_up;
  logic [ONM:0]   w_sum;
  logic signed [INX+1:0] w_ox_rnd;

  // Increment on guard unless it is an exact tie with an even kept value.
  always_comb begin
    w_round_up = i_guard & (i_sticky | i_kept[0]);
    w_sum      = {1'b0, i_kept} + {{ONM{1'b0}}, w_round_up};
    o_carry    = w_sum[ONM];
    o_mant     = w_sum[ONM-1:0];
    w_ox_rnd   = i_ox + $signed({{(INX+1){1'b0}}, o_carry});
    o_overflow = (w_ox_rnd >= OX_MAX);
    o_exp      = w_ox_rnd[ONX-1:0];
    o_inexact  = i_guard | i_sticky;
  end

endmodule

// File: rtl/fp_narrow.sv
// fp_narrow: two-stage pipelined IEEE754 narrowing converter (e.g. double to
// single) with round-to-nearest-even, overflow to infinity, flush-to-zero of
// subnormal results and NaN quieting.
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid/in_ready     - input handshake, in_data = {sign, exp, mant}
//   out_valid/out_ready   - output handshake, out_data = {sign, exp, mant}
//   out_flags             - {overflow, underflow, inexact, nan} for out_data
// S1 unpacks, classifies and rebiases; S2 rounds, packs and raises flags.
module fp_narrow
  import fp_pkg::*;
#(
  parameter int INX = 11,
  parameter int INM = 52,
  parameter int ONX = 8,
  parameter int ONM = 23
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INX+INM:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ONX+ONM:0]   out_data,
  output logic [3:0]         out_flags
);

  localparam int TW = INM - ONM;
  localparam logic signed [INX+1:0] REBIAS = (INX+2)'(exp_offset(ONX) - exp_offset(INX));
  localparam logic signed [INX+1:0] OX_MAX = (INX+2)'((1 << ONX) - 1);

  `FP_FIELDS_T(in_word_t, INX, INM);
  `FP_FIELDS_T(out_word_t, ONX, ONM);

  in_word_t              w_in;
  logic                  w_exp_ones;
  logic                  w_mant_nz;
  logic signed [INX+1:0] w_ox;
  logic [TW-1:0]         w_tail;
  logic [TW-1:0]         w_tail_low;
  logic [ONM-1:0]        w_kept;
  logic                  w_guard;
  logic                  w_sticky;
  fp_class_e             w_cls;
  logic [3:0]            w_flags;

  logic                  w_s1_load;
  logic                  w_s2_load;

  logic                  r_s1_valid;
  logic                  r_s1_sign;
  fp_class_e             r_s1_cls;
  logic signed [INX+1:0] r_s1_ox;
  logic [ONM-1:0]        r_s1_kept;
  logic                  r_s1_guard;
  logic                  r_s1_sticky;
  logic [3:0]            r_s1_flags;

  logic [ONM-1:0]        w_rnd_mant;
  logic [ONX-1:0]        w_rnd_exp;
  logic                  w_rnd_carry;
  logic                  w_rnd_inexact;
  logic                  w_rnd_overflow;
  out_word_t             w_out;
  logic [3:0]            w_out_flags;

  logic                  r_s2_valid;
  logic [ONX+ONM:0]      r_out_data;
  logic [3:0]            r_out_flags;

  assign w_in = in_data;

  // Stage advance: S1 may refill whenever S2 is draining, straight through out_ready.
  always_comb begin
    w_s2_load = ~r_s2_valid | out_ready;
    w_s1_load = ~r_s1_valid | w_s2_load;
  end

  assign in_ready  = w_s1_load;
  assign out_valid = r_s2_valid;
  assign out_data  = r_out_data;
  assign out_flags = r_out_flags;

  // S1 combinational: field split, rebias and class decision in priority order.
  always_comb begin
    w_exp_ones = &w_in.exp;
    w_mant_nz  = |w_in.mant;
    w_ox       = $signed({2'b00, w_in.exp}) + REBIAS;
    w_tail     = w_in.mant[TW-1:0];
    // Shifting out the guard bit leaves only the sticky bits in the tail.
    w_tail_low = w_tail << 1;
    w_guard    = w_tail[TW-1];
    w_sticky   = |w_tail_low;
    w_kept     = w_in.mant[INM-1 -: ONM];
    w_cls      = CL_NORM;
    w_flags    = 4'b0000;
    if (w_exp_ones && w_mant_nz) begin
      w_cls            = CL_NAN;
      w_kept           = {1'b1, w_in.mant[INM-2 -: ONM-1]};
      w_flags[FLG_NAN] = 1'b1;
    end else if (w_exp_ones) begin
      w_cls = CL_INF;
    end else if (w_in.exp == {INX{1'b0}}) begin
      w_cls            = CL_ZERO;
      w_flags[FLG_UNF] = w_mant_nz;
      w_flags[FLG_INX] = w_mant_nz;
    end else if (w_ox <= $signed({(INX+2){1'b0}})) begin
      w_cls            = CL_ZERO;
      w_flags[FLG_UNF] = 1'b1;
      w_flags[FLG_INX] = 1'b1;
    end else if (w_ox >= OX_MAX) begin
      w_cls            = CL_INF;
      w_flags[FLG_OVF] = 1'b1;
      w_flags[FLG_INX] = 1'b1;
    end else begin
      w_cls = CL_NORM;
    end
  end

  // S1 register: captures an input word on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_cls    <= CL_ZERO;
      r_s1_ox     <= {(INX+2){1'b0}};
      r_s1_kept   <= {ONM{1'b0}};
      r_s1_guard  <= 1'b0;
      r_s1_sticky <= 1'b0;
      r_s1_flags  <= 4'b0000;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign   <= w_in.sign;
        r_s1_cls    <= w_cls;
        r_s1_ox     <= w_ox;
        r_s1_kept   <= w_kept;
        r_s1_guard  <= w_guard;
        r_s1_sticky <= w_sticky;
        r_s1_flags  <= w_flags;
      end
    end
  end

  fp_round_rne #(
    .INX (INX),
    .ONX (ONX),
    .ONM (ONM)
  ) u_round (
    .i_kept     (r_s1_kept),
    .i_guard    (r_s1_guard),
    .i_sticky   (r_s1_sticky),
    .i_ox       (r_s1_ox),
    .o_mant     (w_rnd_mant),
    .o_exp      (w_rnd_exp),
    .o_carry    (w_rnd_carry),
    .o_inexact  (w_rnd_inexact),
    .o_overflow (w_rnd_overflow)
  );

  // S2 combinational: pack result by class; a rounding carry may still overflow.
  always_comb begin
    w_out.sign  = r_s1_sign;
    w_out.exp   = {ONX{1'b0}};
    w_out.mant  = {ONM{1'b0}};
    w_out_flags = r_s1_flags;
    case (r_s1_cls)
      CL_NAN: begin
        w_out.exp  = {ONX{1'b1}};
        w_out.mant = r_s1_kept;
      end
      CL_INF: begin
        w_out.exp = {ONX{1'b1}};
      end
      CL_ZERO: begin
        w_out.exp = {ONX{1'b0}};
      end
      CL_NORM: begin
        if (w_rnd_overflow) begin
          w_out.exp            = {ONX{1'b1}};
          w_out_flags[FLG_OVF] = 1'b1;
          w_out_flags[FLG_INX] = 1'b1;
        end else begin
          // On carry the mantissa is already zero and the exponent bumped.
          w_out.exp            = w_rnd_exp;
          w_out.mant           = w_rnd_carry ? {ONM{1'b0}} : w_rnd_mant;
          w_out_flags[FLG_INX] = w_rnd_inexact;
        end
      end
      default: begin
        w_out.exp = {ONX{1'b0}};
      end
    endcase
  end

  // S2 register: holds the output word steady until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_out_data  <= {(ONX+ONM+1){1'b0}};
      r_out_flags <= 4'b0000;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data  <= w_out;
        r_out_flags <= w_out_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_narrow.sv
// tb_fp_narrow: directed self-checking bench for fp_narrow (double to single).
module tb_fp_narrow;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;

  int n_checks = 0;
  int n_errors = 0;

  fp_narrow #(
    .INX (11),
    .INM (52),
    .ONX (8),
    .ONM (23)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One word through an idle pipeline: no output after one edge, result after two.
  task automatic single(input string tag, input logic [63:0] din,
                        input logic [31:0] dexp, input logic [3:0] fexp);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = din;
    out_ready = 1'b1;
    #1;
    check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 64'd0;
    check({tag, "/lat1_valid"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({tag, "/lat2_valid"}, 64'(out_valid), 64'd1);
    check({tag, "/data"}, 64'(out_data), 64'(dexp));
    check({tag, "/flags"}, 64'(out_flags), 64'(fexp));
  endtask

  initial begin
    int          sent;
    int          recv;
    int          cyc;
    logic        stall_prev;
    logic        saw_full;
    logic [31:0] data_prev;
    logic [10:0] wexp;
    logic [51:0] wmant;
    logic [7:0]  oexp;
    logic [22:0] omant;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 64'd0;
    out_ready = 1'b0;
    #1;
    check("rst/out_valid", 64'(out_valid), 64'd0);
    check("rst/out_data", 64'(out_data), 64'd0);
    check("rst/out_flags", 64'(out_flags), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst/in_ready", 64'(in_ready), 64'd1);

    single("one",       64'h3FF0000000000000, 32'h3F800000, 4'b0000);
    single("tie_even",  64'h3FF0000010000000, 32'h3F800000, 4'b0010);
    single("tie_odd",   64'h3FF0000030000000, 32'h3F800002, 4'b0010);
    single("above_tie", 64'h3FF0000018000000, 32'h3F800001, 4'b0010);
    single("below_tie", 64'h3FF0000008000000, 32'h3F800000, 4'b0010);
    single("ovf_exp",   64'h47F0000000000000, 32'h7F800000, 4'b1010);
    single("ovf_carry", 64'h47EFFFFFF0000000, 32'h7F800000, 4'b1010);
    single("max_norm",  64'h47EFFFFFE0000000, 32'h7F7FFFFF, 4'b0000);
    single("qnan",      64'h7FF8000000000000, 32'h7FC00000, 4'b0001);
    single("snan",      64'h7FF0000000000001, 32'h7FC00000, 4'b0001);
    single("nan_pay",   64'hFFF4000000000000, 32'hFFE00000, 4'b0001);
    single("neg_inf",   64'hFFF0000000000000, 32'hFF800000, 4'b0000);
    single("unf",       64'h3690000000000000, 32'h00000000, 4'b0110);
    single("ox_zero",   64'h3800000000000000, 32'h00000000, 4'b0110);
    single("ox_one",    64'h3810000000000000, 32'h00800000, 4'b0000);
    single("subnorm",   64'h0000000000000001, 32'h00000000, 4'b0110);
    single("neg_zero",  64'h8000000000000000, 32'h80000000, 4'b0000);

    // Backpressure: eight words streamed while out_ready cycles 1,0,0,1.
    sent       = 0;
    recv       = 0;
    cyc        = 0;
    stall_prev = 1'b0;
    saw_full   = 1'b0;
    data_prev  = 32'd0;
    while (recv < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      if (sent < 8) begin
        wexp     = 11'(1023 + sent);
        wmant    = 52'(sent) << 40;
        in_valid = 1'b1;
        in_data  = {1'b0, wexp, wmant};
      end else begin
        in_valid = 1'b0;
        in_data  = 64'd0;
      end
      #1;
      if (stall_prev) begin
        check("bp/stall_valid", 64'(out_valid), 64'd1);
        check("bp/stall_data", 64'(out_data), 64'(data_prev));
      end
      if (!in_ready) saw_full = 1'b1;
      if (out_valid && out_ready) begin
        oexp  = 8'(127 + recv);
        omant = 23'(recv) << 11;
        check("bp/data", 64'(out_data), 64'({1'b0, oexp, omant}));
        check("bp/flags", 64'(out_flags), 64'd0);
        recv++;
      end
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    check("bp/count", 64'(recv), 64'd8);
    check("bp/in_ready_low", 64'(saw_full), 64'd1);
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp/no_extra", 64'(out_valid), 64'd0);
    end

    // Reset with both stages holding words.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h3FF0000000000000;
    @(negedge clk);
    in_data = 64'h4000000000000000;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 64'd0;
    #1;
    check("mid/full_valid", 64'(out_valid), 64'd1);
    check("mid/full_in_ready", 64'(in_ready), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid/async_valid", 64'(out_valid), 64'd0);
    check("mid/async_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mid/no_stale", 64'(out_valid), 64'd0);
    end
    single("after_rst", 64'h4000000000000000, 32'h40000000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
